// File: rtl/reg_bus_arbiter_if.sv
// Bundle of SPI-side, internal-fabric and register-bank signals around reg_bus_arbiter.
// slave is the arbiter's view; master is the surrounding logic (SPI block, control FSMs, bank).
interface reg_bus_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] spi_addr;
  logic              spi_write;
  logic              spi_new_req;
  logic [DATA_W-1:0] spi_wdata;
  logic [DATA_W-1:0] spi_rdata;
  logic              spi_in_trans;

  logic              int_req;
  logic              int_we;
  logic [ADDR_W-1:0] int_addr;
  logic [DATA_W-1:0] int_wdata;
  logic              int_ack;
  logic [DATA_W-1:0] int_rdata;

  logic              bank_en;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] bank_rdata;

  logic              spi_overrun;
  logic              spi_wr_err;
  logic [2:0]        dbg_state;

  modport slave (
    input  spi_addr, spi_write, spi_new_req, spi_wdata, spi_in_trans,
    input  int_req, int_we, int_addr, int_wdata,
    input  bank_rdata,
    output spi_rdata, int_ack, int_rdata,
    output bank_en, bank_we, bank_addr, bank_wdata,
    output spi_overrun, spi_wr_err, dbg_state
  );

  modport master (
    output spi_addr, spi_write, spi_new_req, spi_wdata, spi_in_trans,
    output int_req, int_we, int_addr, int_wdata,
    output bank_rdata,
    input  spi_rdata, int_ack, int_rdata,
    input  bank_en, bank_we, bank_addr, bank_wdata,
    input  spi_overrun, spi_wr_err, dbg_state
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Fixed-priority arbiter sharing the single-port register bank between SPI and the internal fabric.
// Optional RO_PROTECT_EN: SPI writes at or above RO_BASE are turned into reads and flag spi_wr_err.
module reg_bus_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8,
  parameter int RO_BASE = 48
) (
  input  logic            clk,
  input  logic            n_rst,
  reg_bus_arbiter_if.slave bus
);

  // Handshakes: spi_new_req is a one-cycle pulse that is never refused; int_req is a level
  // held with its fields until the single-cycle int_ack, which marks completion.
  typedef enum logic [2:0] {IDLE, SPI_ACC, SPI_CAP, INT_ACC, INT_CAP} state_t;

  state_t            state, state_nx;
  logic              spi_pend;
  logic [ADDR_W-1:0] hold_addr;
  logic              hold_we;
  logic [DATA_W-1:0] hold_wdata;
  logic              acc_we;
  logic              bank_en_q, bank_we_q;
  logic [ADDR_W-1:0] bank_addr_q;
  logic [DATA_W-1:0] bank_wdata_q;
  logic [DATA_W-1:0] spi_rdata_q, int_rdata_q;
  logic              overrun_q, wr_err_q;

  logic              spi_req;
  logic [ADDR_W-1:0] spi_c_addr;
  logic              spi_c_we;
  logic [DATA_W-1:0] spi_c_wdata;
  logic              spi_ro;

  // A fresh pulse bypasses the holding register so an idle arbiter hits the bank next cycle.
  always_comb begin
    spi_req     = spi_pend | bus.spi_new_req;
    spi_c_addr  = bus.spi_new_req ? bus.spi_addr  : hold_addr;
    spi_c_we    = bus.spi_new_req ? bus.spi_write : hold_we;
    spi_c_wdata = bus.spi_new_req ? bus.spi_wdata : hold_wdata;
`ifdef RO_PROTECT_EN
    spi_ro      = spi_c_we && (spi_c_addr >= ADDR_W'(RO_BASE));
`else
    spi_ro      = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // SPI_CAP arbitrates like IDLE; INT_CAP ignores int_req because it is still held during its ack.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, SPI_CAP: begin
        if (spi_req)          state_nx = SPI_ACC;
        else if (bus.int_req) state_nx = INT_ACC;
        else                  state_nx = IDLE;
      end
      SPI_ACC: state_nx = SPI_CAP;
      INT_ACC: state_nx = INT_CAP;
      INT_CAP: state_nx = spi_req ? SPI_ACC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      spi_pend     <= 1'b0;
      hold_addr    <= '0;
      hold_we      <= 1'b0;
      hold_wdata   <= '0;
      acc_we       <= 1'b0;
      bank_en_q    <= 1'b0;
      bank_we_q    <= 1'b0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      spi_rdata_q  <= '0;
      int_rdata_q  <= '0;
      overrun_q    <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      bank_en_q <= 1'b0;
      bank_we_q <= 1'b0;
      if (bus.spi_new_req) begin
        hold_addr  <= bus.spi_addr;
        hold_we    <= bus.spi_write;
        hold_wdata <= bus.spi_wdata;
        if (spi_pend) overrun_q <= 1'b1;
      end
      if (state_nx == SPI_ACC)  spi_pend <= 1'b0;
      else if (bus.spi_new_req) spi_pend <= 1'b1;

      if (state_nx == SPI_ACC) begin
        bank_en_q    <= 1'b1;
        bank_we_q    <= spi_c_we & ~spi_ro;
        bank_addr_q  <= spi_c_addr;
        bank_wdata_q <= spi_c_wdata;
        acc_we       <= spi_c_we & ~spi_ro;
        if (spi_ro) wr_err_q <= 1'b1;
      end else if (state_nx == INT_ACC) begin
        bank_en_q    <= 1'b1;
        bank_we_q    <= bus.int_we;
        bank_addr_q  <= bus.int_addr;
        bank_wdata_q <= bus.int_wdata;
        acc_we       <= bus.int_we;
      end

      if (state == SPI_CAP && !acc_we) spi_rdata_q <= bus.bank_rdata;
      if (state == INT_CAP && !acc_we) int_rdata_q <= bus.bank_rdata;
    end
  end

  // int_rdata must be valid alongside int_ack, so the capture cycle forwards bank_rdata directly.
  assign bus.int_ack     = (state == INT_CAP);
  assign bus.int_rdata   = (state == INT_CAP && !acc_we) ? bus.bank_rdata : int_rdata_q;
  assign bus.spi_rdata   = spi_rdata_q;
  assign bus.bank_en     = bank_en_q;
  assign bus.bank_we     = bank_we_q;
  assign bus.bank_addr   = bank_addr_q;
  assign bus.bank_wdata  = bank_wdata_q;
  assign bus.spi_overrun = overrun_q;
  assign bus.dbg_state   = state;
`ifdef RO_PROTECT_EN
  assign bus.spi_wr_err  = wr_err_q;
`else
  assign bus.spi_wr_err  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed plus randomized bench for reg_bus_arbiter against a memory-level reference model.
// Expectations for SPI write protection follow RO_PROTECT_EN when it is defined.
module tb_reg_bus_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int RO = 48;

  typedef struct packed {
    int          c;
    logic [AW-1:0] a;
    logic        we;
    logic [DW-1:0] d;
  } acc_t;

  // clock / reset
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  reg_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RO_BASE(RO)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'((i * 73) ^ 8'h5A);
  endfunction

  // register bank: read data the cycle after bank_en
  logic [DW-1:0] mem [64];
  initial begin
    bus.bank_rdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (bus.bank_en === 1'b1) begin
        bus.bank_rdata <= mem[bus.bank_addr];
        if (bus.bank_we === 1'b1) mem[bus.bank_addr] = bus.bank_wdata;
      end
    end
  end

  // monitor of bank accesses and ack pulses
  acc_t acc_log[$];
  int   ack_count = 0;
  always @(negedge clk) begin
    if (bus.bank_en === 1'b1)
      acc_log.push_back({cyc, bus.bank_addr, bus.bank_we, bus.bank_we ? bus.bank_wdata : 8'h00});
    if (bus.int_ack === 1'b1) ack_count <= ack_count + 1;
  end

  // scoreboard and reference model
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];
  acc_t          exp_acc[$];
  int            log_rd = 0;
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] last_spi = '0;
  logic [DW-1:0] last_int = '0;
  logic          exp_wr_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic spi_blocked(input logic [AW-1:0] a, input logic w);
`ifdef RO_PROTECT_EN
    return w && (int'(a) >= RO);
`else
    return 1'b0;
`endif
  endfunction

  // driver tasks
  task automatic spi_drive(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    bus.spi_addr = a; bus.spi_write = w; bus.spi_wdata = d; bus.spi_new_req = 1'b1;
  endtask

  task automatic int_drive(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    bus.int_addr = a; bus.int_we = w; bus.int_wdata = d; bus.int_req = 1'b1;
  endtask

  task automatic wait_ack(output int ack_c, output logic [DW-1:0] rd);
    ack_c = -1;
    rd = '0;
    for (int i = 0; i < 12; i++) begin
      if (bus.int_ack === 1'b1) begin
        ack_c = cyc;
        rd = bus.int_rdata;
        bus.int_req = 1'b0;
        break;
      end
      tick();
    end
    bus.int_req = 1'b0;
  endtask

  // model: an SPI access reaches the bank at cycle c, an internal one at cycle c
  task automatic model_spi(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input int c);
    logic blk, we_eff;
    blk = spi_blocked(a, w);
    we_eff = w && !blk;
    exp_acc.push_back({c, a, we_eff, we_eff ? d : 8'h00});
    if (we_eff) ref_mem[a] = d;
    else last_spi = ref_mem[a];
    if (blk) exp_wr_err = 1'b1;
    exp_q.push_back(last_spi);
  endtask

  task automatic model_int(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input int c);
    exp_acc.push_back({c, a, w, w ? d : 8'h00});
    if (w) ref_mem[a] = d;
    else last_int = ref_mem[a];
  endtask

  task automatic check_log(input string tag);
    int n;
    check({tag, "_bank_count"}, 64'(acc_log.size() - log_rd), 64'(exp_acc.size()));
    n = (acc_log.size() - log_rd < exp_acc.size()) ? acc_log.size() - log_rd : exp_acc.size();
    for (int i = 0; i < n; i++) check({tag, "_bank_acc"}, acc_log[log_rd + i], exp_acc[i]);
    log_rd = acc_log.size();
    exp_acc.delete();
  endtask

  task automatic do_spi(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    int t;
    t = cyc;
    spi_drive(a, w, d);
    model_spi(a, w, d, t + 1);
    tick();
    bus.spi_new_req = 1'b0;
    tick();
    tick();
    check("spi_rdata_t3", bus.spi_rdata, exp_q.pop_front());
    tick();
    check_log("spi");
  endtask

  task automatic do_int(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    int t, ac;
    logic [DW-1:0] rd;
    t = cyc;
    int_drive(a, w, d);
    model_int(a, w, d, t + 1);
    wait_ack(ac, rd);
    check("int_ack_lat", 64'(ac), 64'(t + 2));
    check("int_rdata", rd, last_int);
    tick();
    check("int_ack_pulse", bus.int_ack, 1'b0);
    check_log("int");
  endtask

  task automatic do_both(input logic [AW-1:0] sa, input logic sw, input logic [DW-1:0] sd,
                         input logic [AW-1:0] ia, input logic iw, input logic [DW-1:0] id);
    int t, ac;
    logic [DW-1:0] rd;
    t = cyc;
    spi_drive(sa, sw, sd);
    int_drive(ia, iw, id);
    model_spi(sa, sw, sd, t + 1);
    model_int(ia, iw, id, t + 3);
    tick();
    bus.spi_new_req = 1'b0;
    wait_ack(ac, rd);
    check("both_ack_lat", 64'(ac), 64'(t + 4));
    check("both_int_rdata", rd, last_int);
    check("both_spi_rdata", bus.spi_rdata, exp_q.pop_front());
    tick();
    check_log("both");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, kind, cnt0;
    logic [AW-1:0] a1, a2, ai;
    logic [DW-1:0] rd;

    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    bus.spi_addr = '0; bus.spi_write = 1'b0; bus.spi_new_req = 1'b0; bus.spi_wdata = '0;
    bus.spi_in_trans = 1'b0;
    bus.int_req = 1'b0; bus.int_we = 1'b0; bus.int_addr = '0; bus.int_wdata = '0;

    // reset state
    n_rst = 1'b0;
    repeat (3) tick();
    check("rst_spi_rdata", bus.spi_rdata, 8'h00);
    check("rst_int_rdata", bus.int_rdata, 8'h00);
    check("rst_int_ack", bus.int_ack, 1'b0);
    check("rst_bank_en", bus.bank_en, 1'b0);
    check("rst_bank_we", bus.bank_we, 1'b0);
    check("rst_bank_addr", bus.bank_addr, 6'h00);
    check("rst_bank_wdata", bus.bank_wdata, 8'h00);
    check("rst_overrun", bus.spi_overrun, 1'b0);
    check("rst_wr_err", bus.spi_wr_err, 1'b0);
    n_rst = 1'b1;
    repeat (5) tick();
    check_log("idle");
    check("idle_int_ack_count", 64'(ack_count), 64'(0));

    // preload via the internal port
    do_int(6'h10, 1'b1, 8'h3C);
    do_int(6'h30, 1'b1, 8'h12);

    // SPI write then read back
    do_spi(6'h05, 1'b1, 8'hA5);
    do_spi(6'h05, 1'b0, 8'h00);
    check("spi_rd_05", bus.spi_rdata, 8'hA5);

    // uncontended internal read
    do_int(6'h10, 1'b0, 8'h00);
    check("int_rd_10", bus.int_rdata, 8'h3C);

    // same-cycle SPI read and internal write
    do_both(6'h01, 1'b0, 8'h00, 6'h02, 1'b1, 8'h77);

    // two SPI pulses on consecutive cycles during an internal access
    check("pre_overrun", bus.spi_overrun, 1'b0);
    a1 = AW'($urandom_range(0, 63));
    a2 = AW'($urandom_range(0, 63));
    ai = AW'($urandom_range(0, 63));
    t = cyc;
    int_drive(ai, 1'b0, 8'h00);
    model_int(ai, 1'b0, 8'h00, t + 1);
    tick();
    spi_drive(a1, 1'b0, 8'h00);
    tick();
    check("ovr_int_ack", bus.int_ack, 1'b1);
    check("ovr_int_rdata", bus.int_rdata, last_int);
    bus.int_req = 1'b0;
    spi_drive(a2, 1'b0, 8'h00);
    model_spi(a2, 1'b0, 8'h00, t + 3);
    tick();
    bus.spi_new_req = 1'b0;
    tick();
    tick();
    check("ovr_spi_rdata", bus.spi_rdata, exp_q.pop_front());
    check("ovr_flag", bus.spi_overrun, 1'b1);
    check_log("ovr");

    // write to the read-only region
    do_spi(6'h30, 1'b1, 8'hFF);
`ifdef RO_PROTECT_EN
    check("ro_spi_rdata", bus.spi_rdata, 8'h12);
    check("ro_wr_err", bus.spi_wr_err, 1'b1);
`else
    check("ro_wr_err", bus.spi_wr_err, 1'b0);
`endif
    do_spi(6'h30, 1'b0, 8'h00);

    // randomized mix
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 2);
      bus.spi_in_trans = 1'($urandom_range(0, 1));
      case (kind)
        0: do_spi(AW'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));
        1: do_int(AW'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));
        default: do_both(AW'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)),
                         AW'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end
    check("sticky_overrun", bus.spi_overrun, 1'b1);
    check("wr_err_final", bus.spi_wr_err, exp_wr_err);

    // reset in the middle of an internal access
    cnt0 = ack_count;
    int_drive(AW'($urandom_range(0, 63)), 1'b1, DW'($urandom_range(0, 255)));
    tick();
    n_rst = 1'b0;
    tick();
    check("abort_int_ack", bus.int_ack, 1'b0);
    check("abort_bank_en", bus.bank_en, 1'b0);
    check("abort_overrun", bus.spi_overrun, 1'b0);
    check("abort_spi_rdata", bus.spi_rdata, 8'h00);
    bus.int_req = 1'b0;
    n_rst = 1'b1;
    repeat (4) tick();
    check("abort_no_ack", 64'(ack_count), 64'(cnt0));
    log_rd = acc_log.size();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
